capture_gate: RTL and testbench

- Sits between each processed/raw 128-bit ADC stream and its readout-buffer AXI4-Stream slave, one instance per channel.
- Gates the free-running ADC stream into a single framed capture: arm, wait for trigger, skip a programmable number of beats, then forward exactly N beats with tlast on the final beat.
- The ADC source never stalls. Downstream backpressure therefore causes dropped beats, which the block reports as overflow.

---
 rtl/capture_gate_if.sv | 26 ++
 rtl/capture_gate.sv | 209 ++++++++++++++++++++
 tb/tb_capture_gate.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_gate_if.sv
// AXI4-Stream style beat bundle used on both sides of capture_gate.
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready
// are both high; once tvalid is raised, tdata/tlast hold until that edge.
interface capture_gate_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  // Producer side of the stream.
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Consumer side; the ADC source carries no framing, so tlast is not read.
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/capture_gate.sv
// capture_gate: gates a free-running ADC beat stream into one framed capture.
// Flow: arm (latch config) -> wait for trigger -> skip trig_delay valid beats
// (counting the trigger-cycle beat) -> forward capture_len beats through a
// one-deep output register, tlast on the final one. The source never stalls,
// so a beat arriving while the register is full and stalled is dropped and
// flagged on the sticky overflow_o; dropped beats are not counted, so the
// capture always delivers exactly capture_len beats.
module capture_gate #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  capture_gate_if.slave        s_axis,
  capture_gate_if.master       m_axis,
  input  logic                 arm_i,
  input  logic                 trig_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] trig_delay_i,
  input  logic [LEN_WIDTH-1:0] capture_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [LEN_WIDTH-1:0] beat_count_o,
  output logic [2:0]           state_dbg_o
);

  localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_CAPT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Reset: asserts immediately, releases two aclk edges after aresetn rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchroniser: async assert, sync deassert.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  delay_q, delay_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  ovf_q;
  logic                  done_q, done_d;

  logic hs;          // output beat leaves on this edge
  logic slot_free;   // output register can take a new beat this edge
  logic capt_en;     // incoming valid beat belongs to the capture window
  logic load;        // beat is written into the output register
  logic load_last;   // the loaded beat completes the capture
  logic drop;        // beat lost to backpressure
  logic arm_take;    // configuration latched this edge
  logic force_last;  // abort while a beat is stuck in the register

  assign hs        = valid_q & m_axis.tready;
  assign slot_free = ~valid_q | m_axis.tready;
  assign cnt_inc   = cnt_q + ONE;

  // Next-state and control decode; abort wins over arm and trig.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    done_d     = hs & last_q;
    capt_en    = 1'b0;
    arm_take   = 1'b0;
    force_last = 1'b0;
    load       = 1'b0;
    load_last  = 1'b0;
    drop       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (arm_i) begin
          arm_take = 1'b1;
          state_d  = S_ARMED;
          delay_d  = trig_delay_i;
          len_d    = (capture_len_i == '0) ? ONE : capture_len_i;
          cnt_d    = '0;
        end
      end
      S_ARMED: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (trig_i) begin
          if (delay_q == '0) begin
            // The beat in the trigger cycle is the first captured beat.
            state_d = S_CAPT;
            capt_en = 1'b1;
          end else begin
            // The trigger-cycle beat is the first skipped beat.
            if (s_axis.tvalid) delay_d = delay_q - ONE;
            state_d = (s_axis.tvalid && delay_q == ONE) ? S_CAPT : S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (s_axis.tvalid) begin
          delay_d = delay_q - ONE;
          if (delay_q == ONE) state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort_i) begin
          // A stalled beat is closed off with tlast; an empty (or emptying)
          // register means there is nothing left to frame.
          if (valid_q && !m_axis.tready) begin
            force_last = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          capt_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (hs) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capt_en && s_axis.tvalid) begin
      if (slot_free) begin
        load      = 1'b1;
        cnt_d     = cnt_inc;
        load_last = (cnt_inc == len_q);
        if (load_last) state_d = S_DRAIN;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // FSM state and counters.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Sticky overflow, cleared only by a new arm.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n)        ovf_q <= 1'b0;
    else if (arm_take) ovf_q <= 1'b0;
    else if (drop)     ovf_q <= 1'b1;
  end

  // One-deep output register; contents hold while stalled.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      last_q  <= load_last;
      data_q  <= s_axis.tdata;
    end else if (hs) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (force_last) begin
      last_q  <= 1'b1;
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign beat_count_o = cnt_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_capture_gate.sv
// Bench for capture_gate: random ADC traffic and random/windowed backpressure,
// checked against a beat-level reference model and an expected-beat queue.
module tb_capture_gate;

  localparam int DW = 128;
  localparam int LW = 16;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  capture_gate_if #(.DATA_WIDTH(DW)) s_if ();
  capture_gate_if #(.DATA_WIDTH(DW)) m_if ();

  logic          arm_i, trig_i, abort_i;
  logic [LW-1:0] trig_delay_i, capture_len_i;
  logic          busy_o, done_o, overflow_o;
  logic [LW-1:0] beat_count_o;
  logic [2:0]    state_dbg_o;

  capture_gate #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .arm_i         (arm_i),
    .trig_i        (trig_i),
    .abort_i       (abort_i),
    .trig_delay_i  (trig_delay_i),
    .capture_len_i (capture_len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o),
    .beat_count_o  (beat_count_o),
    .state_dbg_o   (state_dbg_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  bit            exp_last_q[$];

  bit m_armed, m_capt, m_full, m_full_last, m_ovf, exp_done_next;
  int m_skip, m_taken, m_len, m_delay_cfg;
  int cfg_delay, cfg_len;

  // stimulus controls
  int vpct = 100;
  int rpct = 100;
  int ofs = -1;
  int lo_from = -1;
  int lo_to = -1;
  logic [31:0] ramp = '0;

  // stall tracking
  bit            prev_stall, prev_abort;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic model_reset();
    exp_q.delete();
    exp_last_q.delete();
    m_armed = 0; m_capt = 0; m_full = 0; m_full_last = 0; m_ovf = 0;
    exp_done_next = 0; m_skip = 0; m_taken = 0; m_len = 1; m_delay_cfg = 0;
    prev_stall = 0; prev_abort = 0;
  endtask

  // One clock cycle: check last edge's results, drive this cycle, score it.
  task automatic step(input bit arm, input bit trig, input bit abort);
    bit sval, rdy, acc;
    logic [DW-1:0] d;
    @(posedge aclk);
    #1;
    check("done_o", done_o, exp_done_next);
    check("m_tvalid", m_if.tvalid, m_full);
    if (prev_stall) begin
      check("stall_tdata", m_if.tdata, prev_data);
      if (!prev_abort) check("stall_tlast", m_if.tlast, prev_last);
    end

    sval = ($urandom_range(99) < vpct);
    rdy  = ($urandom_range(99) < rpct);
    if (ofs >= lo_from && ofs <= lo_to) rdy = 0;
    d = {$urandom, $urandom, $urandom, ramp};
    ramp++;
    arm_i = arm; trig_i = trig; abort_i = abort;
    s_if.tvalid = sval; s_if.tdata = d; m_if.tready = rdy;
    #1;

    if (m_if.tvalid && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("beat_data", m_if.tdata, exp_q.pop_front());
        check("beat_last", m_if.tlast, exp_last_q.pop_front());
      end
    end
    prev_stall = m_if.tvalid && !rdy;
    prev_data  = m_if.tdata;
    prev_last  = m_if.tlast;
    prev_abort = abort;

    // Reference: which beats end up in the capture, and when it finishes.
    exp_done_next = m_full && rdy && m_full_last;
    acc = 0;
    if (abort) begin
      if (m_full && !rdy) begin
        m_full_last = 1;
        exp_last_q[exp_last_q.size()-1] = 1;
      end
      m_armed = 0; m_capt = 0;
    end else begin
      if (m_armed && trig) begin
        m_armed = 0; m_capt = 1; m_skip = m_delay_cfg;
      end else if (arm && !m_armed && !m_capt && !m_full) begin
        m_armed = 1; m_delay_cfg = cfg_delay;
        m_len = (cfg_len == 0) ? 1 : cfg_len;
        m_taken = 0; m_ovf = 0;
      end
      if (m_capt && sval) begin
        if (m_skip > 0) begin
          m_skip--;
        end else if (!m_full || rdy) begin
          acc = 1;
          m_taken++;
          exp_q.push_back(d);
          exp_last_q.push_back(m_taken == m_len);
          if (m_taken == m_len) m_capt = 0;
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (acc) begin
      m_full = 1; m_full_last = (m_taken == m_len);
    end else if (m_full && rdy) begin
      m_full = 0; m_full_last = 0;
    end
    if (ofs >= 0) ofs++;
  endtask

  // ---------------- driver: one full arm/trigger/capture ----------------
  task automatic run_capture(input int delay, input int len, input int pre_gap, input int abort_at);
    int budget;
    cfg_delay = delay; cfg_len = len;
    trig_delay_i = LW'(delay); capture_len_i = LW'(len);
    ofs = -1;
    step(1, 0, 0);
    repeat (pre_gap) step(0, 0, 0);
    ofs = 0;
    step(0, 1, abort_at == 0);
    budget = 0;
    while ((m_armed || m_capt || m_full) && budget < 3000) begin
      step(0, 0, ofs == abort_at);
      budget++;
    end
    if (budget >= 3000) check("timeout", 1, 0);
    step(0, 0, 0);
    check("overflow_o", overflow_o, m_ovf);
    check("beat_count_o", beat_count_o, m_taken);
    check("scoreboard_empty", exp_q.size(), 0);
    ofs = -1; lo_from = -1; lo_to = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    arm_i = 0; trig_i = 0; abort_i = 0;
    trig_delay_i = '0; capture_len_i = '0;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0;
    m_if.tready = 1;
    model_reset();

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tlast", m_if.tlast, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_beat_count", beat_count_o, 0);
    aresetn = 1;
    repeat (4) @(posedge aclk);

    // delay 0, len 4, continuous traffic
    vpct = 100; rpct = 100;
    run_capture(0, 4, 1, -1);
    check("tp1_count", beat_count_o, 4);
    check("tp1_overflow", overflow_o, 0);

    // delay 3, len 2: first beat is trigger beat + 3
    run_capture(3, 2, 2, -1);
    check("tp2_count", beat_count_o, 2);

    // len 8 with ready held low for 3 cycles mid-capture
    lo_from = 3; lo_to = 5;
    run_capture(0, 8, 0, -1);
    check("tp3_overflow", overflow_o, 1);
    check("tp3_count", beat_count_o, 8);

    // length 0 behaves as length 1
    run_capture(0, 0, 1, -1);
    check("tp4_len0_count", beat_count_o, 1);

    // trigger coincident with arm is ignored; abort in ARMED goes idle
    cfg_delay = 0; cfg_len = 3;
    trig_delay_i = '0; capture_len_i = 16'd3;
    step(1, 1, 0);
    repeat (5) step(0, 0, 0);
    check("armed_busy", busy_o, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check("abort_armed_busy", busy_o, 0);
    step(0, 0, 0);

    // abort mid-capture with a stalled beat in the register
    lo_from = 3; lo_to = 7;
    run_capture(0, 10, 0, 5);
    check("tp5_count", beat_count_o, 3);

    // reset asserted mid-capture
    cfg_delay = 0; cfg_len = 20;
    trig_delay_i = '0; capture_len_i = 16'd20;
    rpct = 50;
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    @(posedge aclk);
    #3;
    aresetn = 0;
    #1;
    check("async_rst_tvalid", m_if.tvalid, 0);
    check("async_rst_tlast", m_if.tlast, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_count", beat_count_o, 0);
    arm_i = 0; trig_i = 0; abort_i = 0;
    model_reset();
    repeat (3) @(posedge aclk);
    #2;
    aresetn = 1;
    repeat (4) @(posedge aclk);
    rpct = 100;
    run_capture(1, 6, 1, -1);
    check("post_rst_overflow", overflow_o, 0);

    // randomized captures
    for (int i = 0; i < 24; i++) begin
      vpct = $urandom_range(40, 100);
      rpct = $urandom_range(30, 100);
      run_capture($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 3),
                  ($urandom_range(3) == 0) ? $urandom_range(0, 10) : -1);
    end

    // longer capture under moderate backpressure
    vpct = 90; rpct = 70;
    run_capture(2, 300, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
